// File: rtl/ps2_rx_axis.sv
// ps2_rx_axis: PS/2 device-to-host frame receiver feeding an AXI-Stream master through a byte FIFO
// ports: axis_aclk_i clock, axis_aresetn_i async active-low reset; ps2_clk/ps2_data raw pins;
//        m_axis_tready_i/m_axis_tvalid_o/m_axis_tdata_o AXI-Stream master;
//        frame_err_o parity/stop/timeout pulse; overflow_o pulse when a good byte meets a full FIFO
module ps2_rx_axis #(
  parameter int FIFO_DEPTH = 8,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       axis_aclk_i,
  input  logic       axis_aresetn_i,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       m_axis_tready_i,
  output logic       m_axis_tvalid_o,
  output logic [7:0] m_axis_tdata_o,
  output logic       frame_err_o,
  output logic       overflow_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [1:0] csync_q, dsync_q;
  logic fclk_q, fall_q, flip, sdat;
  logic [FW-1:0] flt_q;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic par_q, par_d;
  logic [TW-1:0] to_q, to_d;
  logic err_q, err_d, ovf_q, push, pop, wr_en;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  assign sdat = dsync_q[1];
  // fclk only moves after FILTER_LEN consecutive disagreeing samples
  assign flip = (csync_q[1] != fclk_q) && (flt_q == FW'(FILTER_LEN - 1));
  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i)
    if (!axis_aresetn_i) begin
      csync_q <= 2'b11;
      dsync_q <= 2'b11;
      fclk_q  <= 1'b1;
      flt_q   <= '0;
      fall_q  <= 1'b0;
    end else begin
      csync_q <= {csync_q[0], ps2_clk};
      dsync_q <= {dsync_q[0], ps2_data};
      flt_q   <= (csync_q[1] == fclk_q || flip) ? '0 : flt_q + 1'b1;
      fclk_q  <= flip ? csync_q[1] : fclk_q;
      fall_q  <= flip && !csync_q[1];
    end
  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i)
    if (!axis_aresetn_i) begin
      state_q <= IDLE;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      to_q    <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      to_q    <= to_d;
      err_q   <= err_d;
      ovf_q   <= push && !wr_en;
    end
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    to_d    = (state_q == IDLE || fall_q) ? '0 : to_q + 1'b1;
    err_d   = 1'b0;
    push    = 1'b0;
    if (state_q != IDLE && to_q == TW'(TIMEOUT)) begin
      state_d = IDLE;
      to_d    = '0;
      err_d   = 1'b1;
    end else if (fall_q)
      case (state_q)
        IDLE: begin
          state_d = sdat ? IDLE : DATA;
          bit_d   = '0;
        end
        DATA: begin
          sh_d    = {sdat, sh_q[7:1]};
          bit_d   = bit_q + 1'b1;
          state_d = (bit_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_d   = sdat;
          state_d = STOP;
        end
        STOP: begin
          push    = sdat && (^{sh_q, par_q});
          err_d   = !push;
          state_d = IDLE;
        end
      endcase
  end
  // a full FIFO still accepts a byte when the head leaves in the same cycle
  assign pop             = m_axis_tvalid_o && m_axis_tready_i;
  assign wr_en           = push && (cnt_q != (AW+1)'(FIFO_DEPTH) || pop);
  assign m_axis_tvalid_o = cnt_q != '0;
  assign m_axis_tdata_o  = m_axis_tvalid_o ? mem[rd_q] : 8'h00;
  assign frame_err_o     = err_q;
  assign overflow_o      = ovf_q;
  always_ff @(posedge axis_aclk_i or negedge axis_aresetn_i)
    if (!axis_aresetn_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(wr_en);
      rd_q  <= rd_q + AW'(pop);
      cnt_q <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    end
  always_ff @(posedge axis_aclk_i)
    if (wr_en) mem[wr_q] <= sh_q;
endmodule

// File: tb/tb_ps2_rx_axis.sv
// tb_ps2_rx_axis: directed checks of the PS/2 receiver with a shortened bit period and timeout
module tb_ps2_rx_axis;
  localparam int H  = 40;
  localparam int TO = 2000;
  logic clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1, tready = 1'b0;
  logic tvalid, err, ovf;
  logic [7:0] tdata;
  int errors = 0, checks = 0, err_cnt = 0, ovf_cnt = 0;
  logic [7:0] beats [$];
  ps2_rx_axis #(.FIFO_DEPTH(8), .FILTER_LEN(8), .TIMEOUT(TO)) dut (
    .axis_aclk_i(clk), .axis_aresetn_i(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .m_axis_tready_i(tready), .m_axis_tvalid_o(tvalid), .m_axis_tdata_o(tdata),
    .frame_err_o(err), .overflow_o(ovf));
  always #10 clk = ~clk;
  always @(negedge clk)
    if (rst_n) begin
      if (err) err_cnt++;
      if (ovf) ovf_cnt++;
      if (tvalid && tready) beats.push_back(tdata);
    end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // bits are sent LSB first: start, data[0..7], parity, stop
  task automatic send_bits(input logic [10:0] bits, input int n, input bit pop_stop);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      idle(H / 2);
      ps2_clk = 1'b0;
      if (pop_stop && i == 10) begin
        idle(10);
        tready = 1'b1;
        idle(1);
        tready = 1'b0;
        idle(H - 11);
      end else idle(H);
      ps2_clk = 1'b1;
      idle(H / 2);
    end
    ps2_data = 1'b1;
  endtask
  task automatic send(input logic [7:0] b, input logic par, input logic stop);
    send_bits({stop, par, b, 1'b0}, 11, 1'b0);
    idle(50);
  endtask
  task automatic test_reset;
    #1;
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", tvalid); end
    checks++; if (tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata: got %h expected 00", tdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    idle(3);
    rst_n = 1'b1;
    idle(5);
  endtask
  task automatic test_clean;
    int b0 = beats.size(), e0 = err_cnt;
    tready = 1'b1;
    send(8'h1C, 1'b0, 1'b1);
    checks++; if (beats.size() - b0 !== 1) begin errors++; $display("FAIL clean_beats: got %0d expected 1", beats.size() - b0); end
    else begin
      checks++; if (beats[b0] !== 8'h1C) begin errors++; $display("FAIL clean_data: got %h expected 1c", beats[b0]); end
    end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL clean_err: got %0d expected 0", err_cnt - e0); end
  endtask
  task automatic test_errors;
    int b0 = beats.size(), e0 = err_cnt;
    send(8'h1C, 1'b1, 1'b1);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL parity_err: got %0d expected 1", err_cnt - e0); end
    send(8'hF0, 1'b1, 1'b0);
    checks++; if (err_cnt - e0 !== 2) begin errors++; $display("FAIL stop_err: got %0d expected 2", err_cnt - e0); end
    checks++; if (beats.size() - b0 !== 0) begin errors++; $display("FAIL err_beats: got %0d expected 0", beats.size() - b0); end
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL err_tvalid: got %b expected 0", tvalid); end
  endtask
  task automatic test_overflow;
    int b0 = beats.size(), o0 = ovf_cnt;
    logic [7:0] b;
    tready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      b = 8'(i);
      send(b, ~^b, 1'b1);
    end
    checks++; if (ovf_cnt - o0 !== 0) begin errors++; $display("FAIL ovf_early: got %0d expected 0", ovf_cnt - o0); end
    send(8'h09, 1'b1, 1'b1);
    checks++; if (ovf_cnt - o0 !== 1) begin errors++; $display("FAIL ovf_9th: got %0d expected 1", ovf_cnt - o0); end
    checks++; if (tvalid !== 1'b1 || tdata !== 8'h01) begin errors++; $display("FAIL ovf_hold: got v=%b d=%h expected v=1 d=01", tvalid, tdata); end
    tready = 1'b1;
    idle(12);
    checks++; if (beats.size() - b0 !== 8) begin errors++; $display("FAIL ovf_beats: got %0d expected 8", beats.size() - b0); end
    else for (int i = 0; i < 8; i++) begin
      checks++; if (beats[b0 + i] !== 8'(i + 1)) begin errors++; $display("FAIL ovf_order%0d: got %h expected %h", i, beats[b0 + i], 8'(i + 1)); end
    end
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b expected 0", tvalid); end
  endtask
  task automatic test_glitch;
    int b0 = beats.size(), e0 = err_cnt;
    ps2_clk = 1'b0;
    ps2_data = 1'b0;
    idle(3);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    idle(30);
    send(8'h5A, 1'b1, 1'b1);
    checks++; if (beats.size() - b0 !== 1) begin errors++; $display("FAIL glitch_beats: got %0d expected 1", beats.size() - b0); end
    else begin
      checks++; if (beats[b0] !== 8'h5A) begin errors++; $display("FAIL glitch_data: got %h expected 5a", beats[b0]); end
    end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL glitch_err: got %0d expected 0", err_cnt - e0); end
  endtask
  task automatic test_timeout;
    int b0 = beats.size(), e0 = err_cnt;
    send_bits({3'b111, 8'hF0, 1'b0}, 4, 1'b0);
    idle(TO + 10);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL timeout_err: got %0d expected 1", err_cnt - e0); end
    send(8'hF0, 1'b1, 1'b1);
    checks++; if (beats.size() - b0 !== 1) begin errors++; $display("FAIL timeout_beats: got %0d expected 1", beats.size() - b0); end
    else begin
      checks++; if (beats[b0] !== 8'hF0) begin errors++; $display("FAIL timeout_data: got %h expected f0", beats[b0]); end
    end
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL timeout_err_after: got %0d expected 1", err_cnt - e0); end
  endtask
  task automatic test_reset_mid;
    int b0, e0;
    tready = 1'b0;
    send(8'h11, 1'b1, 1'b1);
    send(8'h22, 1'b1, 1'b1);
    checks++; if (tvalid !== 1'b1 || tdata !== 8'h11) begin errors++; $display("FAIL mid_queued: got v=%b d=%h expected v=1 d=11", tvalid, tdata); end
    send_bits({3'b111, 8'h33, 1'b0}, 5, 1'b0);
    ps2_data = 1'b1;
    idle(H / 2);
    ps2_clk = 1'b0;
    idle(15);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (tvalid !== 1'b0 || tdata !== 8'h00) begin errors++; $display("FAIL mid_async: got v=%b d=%h expected v=0 d=00", tvalid, tdata); end
    checks++; if (err !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL mid_pulses: got err=%b ovf=%b expected 0 0", err, ovf); end
    idle(3);
    ps2_clk = 1'b1;
    idle(20);
    rst_n = 1'b1;
    idle(30);
    b0 = beats.size();
    e0 = err_cnt;
    tready = 1'b1;
    send(8'h29, 1'b0, 1'b1);
    checks++; if (beats.size() - b0 !== 1) begin errors++; $display("FAIL mid_beats: got %0d expected 1", beats.size() - b0); end
    else begin
      checks++; if (beats[b0] !== 8'h29) begin errors++; $display("FAIL mid_data: got %h expected 29", beats[b0]); end
    end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL mid_err: got %0d expected 0", err_cnt - e0); end
  endtask
  task automatic test_full_pop_push;
    int b0 = beats.size(), o0 = ovf_cnt;
    logic [7:0] b;
    tready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      b = 8'(i);
      send(b, ~^b, 1'b1);
    end
    send_bits({1'b1, 1'b1, 8'h0A, 1'b0}, 11, 1'b1);
    idle(20);
    checks++; if (ovf_cnt - o0 !== 0) begin errors++; $display("FAIL full_ovf: got %0d expected 0", ovf_cnt - o0); end
    checks++; if (tvalid !== 1'b1 || tdata !== 8'h02) begin errors++; $display("FAIL full_head: got v=%b d=%h expected v=1 d=02", tvalid, tdata); end
    tready = 1'b1;
    idle(12);
    checks++; if (beats.size() - b0 !== 9) begin errors++; $display("FAIL full_beats: got %0d expected 9", beats.size() - b0); end
    else begin
      checks++; if (beats[b0] !== 8'h01) begin errors++; $display("FAIL full_first: got %h expected 01", beats[b0]); end
      checks++; if (beats[b0 + 8] !== 8'h0A) begin errors++; $display("FAIL full_last: got %h expected 0a", beats[b0 + 8]); end
    end
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL full_drained: got %b expected 0", tvalid); end
  endtask
  initial begin
    test_reset;
    test_clean;
    test_errors;
    test_overflow;
    test_glitch;
    test_timeout;
    test_reset_mid;
    test_full_pop_push;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
